// File: rtl/clock_pkg.sv
// Shared definitions for the time-of-day sequencer: mode encodings and field widths.
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN     = 2'd0,
        MODE_SET_HR  = 2'd1,
        MODE_SET_MIN = 2'd2
    } mode_t;

    localparam int SEC_MAX = 60;
    localparam int SEC_W   = 6;
    localparam int HOUR_W  = 5;

    // True for either of the two user-adjust states.
    function automatic logic isSetMode(input mode_t m);
        return (m == MODE_SET_HR) || (m == MODE_SET_MIN);
    endfunction

endpackage

// File: rtl/mod_n_counter.sv
// Modulo-N counter with clear priority over enable and a combinational wrap carry.
module mod_n_counter #(
    parameter int N = 60,
    parameter int W = 6
) (
    input  logic         mclk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] q,
    output logic         carry
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    // Count register: clear beats enable, wraps from N-1 back to zero.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= (q == LAST) ? '0 : q + 1'b1;
        end
    end

    assign carry = en & (q == LAST);

endmodule

// File: rtl/clock_mode_ctrl.sv
// Time-of-day sequencer: chained sec/min/hour counters plus a two-button set-mode FSM.
// Optional field blinking in the set states is built when CLOCK_MODE_CTRL_BLINK_EN is defined.
module clock_mode_ctrl
    import clock_pkg::*;
#(
    parameter int HOUR_MAX = 24
) (
    input  logic              mclk,
    input  logic              reset,
    input  logic              tick_1s,
    input  logic              btn_mode,
    input  logic              btn_inc,
    output logic [SEC_W-1:0]  sec,
    output logic [SEC_W-1:0]  min,
    output logic [HOUR_W-1:0] hour,
    output logic [1:0]        mode,
    output logic [2:0]        blank
);

    mode_t r_state;
    mode_t w_nextState;
    logic  r_modeQ;
    logic  r_incQ;
    logic  w_modeEdge;
    logic  w_incEdge;
    logic  w_secEn;
    logic  w_secClr;
    logic  w_minEn;
    logic  w_hourEn;
    logic  w_secCarry;
    logic  w_minCarry;
    logic  w_hourCarryUnused;

    assign w_modeEdge = btn_mode & ~r_modeQ;
    assign w_incEdge  = btn_inc & ~r_incQ;

    // Button history so each press produces exactly one action however long it is held.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            r_modeQ <= 1'b0;
            r_incQ  <= 1'b0;
        end else begin
            r_modeQ <= btn_mode;
            r_incQ  <= btn_inc;
        end
    end

    // Mode state register.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            r_state <= MODE_RUN;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and counter controls; a mode press always wins over an increment press.
    always_comb begin
        w_nextState = r_state;
        w_secEn     = 1'b0;
        w_secClr    = 1'b0;
        w_minEn     = 1'b0;
        w_hourEn    = 1'b0;
        case (r_state)
            MODE_RUN: begin
                w_secEn  = tick_1s;
                w_minEn  = w_secCarry;
                w_hourEn = w_minCarry;
                if (w_modeEdge) begin
                    w_nextState = MODE_SET_HR;
                end
            end
            MODE_SET_HR: begin
                if (w_modeEdge) begin
                    w_nextState = MODE_SET_MIN;
                end else begin
                    w_hourEn = w_incEdge;
                end
            end
            MODE_SET_MIN: begin
                if (w_modeEdge) begin
                    w_nextState = MODE_RUN;
                    w_secClr    = 1'b1;
                end else begin
                    w_minEn = w_incEdge;
                end
            end
            default: begin
                w_nextState = MODE_RUN;
            end
        endcase
    end

    mod_n_counter #(.N(SEC_MAX), .W(SEC_W)) u_secCounter (
        .mclk  (mclk),
        .reset (reset),
        .en    (w_secEn),
        .clr   (w_secClr),
        .q     (sec),
        .carry (w_secCarry)
    );

    mod_n_counter #(.N(SEC_MAX), .W(SEC_W)) u_minCounter (
        .mclk  (mclk),
        .reset (reset),
        .en    (w_minEn),
        .clr   (1'b0),
        .q     (min),
        .carry (w_minCarry)
    );

    mod_n_counter #(.N(HOUR_MAX), .W(HOUR_W)) u_hourCounter (
        .mclk  (mclk),
        .reset (reset),
        .en    (w_hourEn),
        .clr   (1'b0),
        .q     (hour),
        .carry (w_hourCarryUnused)
    );

    assign mode = r_state;

`ifdef CLOCK_MODE_CTRL_BLINK_EN
    logic r_blinkPh;

    // Blink phase: held low in RUN, toggles per second while setting, forced visible on an increment.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            r_blinkPh <= 1'b0;
        end else if ((r_state == MODE_RUN) || (w_nextState == MODE_RUN)) begin
            r_blinkPh <= 1'b0;
        end else if (w_incEdge) begin
            r_blinkPh <= 1'b0;
        end else if (tick_1s && isSetMode(r_state)) begin
            r_blinkPh <= ~r_blinkPh;
        end
    end

    assign blank = {(r_state == MODE_SET_HR) & r_blinkPh,
                    (r_state == MODE_SET_MIN) & r_blinkPh,
                    1'b0};
`else
    assign blank = 3'b000;
`endif

endmodule
